sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock synchronous FIFO; successor to the fixed 8x64 FIFO.
//   Adds configurable width/depth, occupancy count, almost-full/almost-empty thresholds and simultaneous
//   read+write when full. Sits between producer/consumer stages in the datapath; drives the same IF-style bench.
// PARAMETERS
//   DATA_W    8    data word width in bits (>=1)
//   DEPTH     64   number of entries; power of two, >=4
//   AF_THRESH 56   almost_full asserts when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH 8    almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//   clk          in   1                 rising-edge clock
//   reset        in   1                 synchronous, active-high reset
//   wr           in   1                 write request
//   rd           in   1                 read request
//   data_in      in   DATA_W            write data
//   data_out     out  DATA_W            read data, registered
//   full         out  1                 count == DEPTH
//   empty        out  1                 count == 0
//   almost_full  out  1                 count >= AF_THRESH
//   almost_empty out  1                 count <= AE_THRESH
//   count        out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   err_clr      in   1                 clears sticky error flags (used only with FIFO_ERR_EN)
//   overflow     out  1                 sticky: wr rejected (FIFO_ERR_EN)
//   underflow    out  1                 sticky: rd rejected (FIFO_ERR_EN)
// BEHAVIOUR
//   - Reset (sync, active-high, sampled on clk edge): wr_ptr=rd_ptr=0, count=0, data_out=0, overflow=underflow=0.
//     Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not cleared.
//   - Reset dominates wr/rd in the same cycle; reset mid-operation discards all stored data.
//   - wr_acc = wr & (!full | rd_acc);  rd_acc = rd & !empty.
//   - wr_acc: mem[wr_ptr]<=data_in, wr_ptr+1. rd_acc: data_out<=mem[rd_ptr], rd_ptr+1.
//   - Read latency 1 cycle: data valid on data_out the cycle after rd_acc; data_out holds otherwise.
//   - count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
//   - Full & rd & wr: both accepted, count stays DEPTH, oldest word out, new word in.
//   - Empty & rd & wr: write accepted, read rejected (no bypass); data_out holds; count -> 1.
//   - Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH naturally; no extra pointer bit needed (count disambiguates).
//   - full/empty/almost_* are combinational decodes of registered count; no extra latency.
// CONFIGURATION
//   FIFO_ERR_EN defined: overflow<=1 on wr & !wr_acc; underflow<=1 on rd & !rd_acc; both sticky until
//     err_clr or reset. err_clr and a new error in same cycle: error wins (flag stays 1).
//   FIFO_ERR_EN undefined: overflow=underflow=0 constant, err_clr ignored; no flag flops synthesised.
//   Rejected wr/rd never change state in either configuration.
// STRUCTURE
//   fifo_pkg: localparam helpers (PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1), typedef fifo_status_t packed
//     struct {full, empty, almost_full, almost_empty} shared with the bench scoreboard.
//   Sub-module fifo_mem: DEPTH x DATA_W register array, one sync write port, one sync registered read port.
//   Top holds pointers, count, flag decode, error flags; elaboration-time assertion on DEPTH power of two
//     and threshold ranges.
// TESTING (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
//   1 Reset then write 0x01..0x10 (16 writes) -> count=16, full=1, almost_full=1 from 14th write; read 16 ->
//     data_out 0x01..0x10 in order, one cycle after each rd, empty=1 at end.
//   2 Full, assert wr+rd with data_in=0xAA -> count stays 16, data_out=oldest word, 0xAA read last.
//   3 Empty, assert wr+rd with data_in=0x55 -> count=1, data_out unchanged; next rd -> data_out=0x55.
//   4 Write 20 words without reads -> writes 17..20 rejected, count=16; with FIFO_ERR_EN overflow=1 until
//     err_clr pulse, then 0; read on empty -> underflow=1. Without macro both stay 0.
//   5 Fill 10, assert reset one cycle while wr=1 -> next cycle count=0, empty=1, data_out=0x00.
//   6 Wrap: 40 interleaved write/read pairs with random data -> scoreboard match, pointers wrap past 15.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and sizing helpers for sync_fifo_param (optional feature macro: FIFO_ERR_EN)
package fifo_pkg;

  // Status flags grouped for the design and the bench scoreboard.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Pointer width; wraps modulo DEPTH because DEPTH is a power of two.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit to represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array with one sync write port and one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage is never cleared; the caller gates writes during reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register resets to zero and holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, thresholds and optional sticky errors (FIFO_ERR_EN)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fifo_status_t     w_status;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Flags are pure decodes of the registered count, so they track it with no extra latency.
  always_comb begin
    w_status              = '0;
    w_status.full         = (r_count == CNT_W'(DEPTH));
    w_status.empty        = (r_count == '0);
    w_status.almost_full  = (r_count >= CNT_W'(AF_THRESH));
    w_status.almost_empty = (r_count <= CNT_W'(AE_THRESH));
  end

  // A read frees a slot in the same cycle, so a full FIFO accepts wr+rd together; empty never bypasses.
  assign w_rd_acc = rd & ~w_status.empty;
  assign w_wr_acc = wr & (~w_status.full | w_rd_acc);

  // Pointer and occupancy update; reset dominates any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_acc & ~reset),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_acc & ~reset),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (data_out)
  );

  assign full         = w_status.full;
  assign empty        = w_status.empty;
  assign almost_full  = w_status.almost_full;
  assign almost_empty = w_status.almost_empty;
  assign count        = r_count;

`ifdef FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr & ~w_wr_acc) r_overflow <= 1'b1;
      else if (err_clr)   r_overflow <= 1'b0;
      if (rd & ~w_rd_acc) r_underflow <= 1'b1;
      else if (err_clr)   r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - table-driven self-checking bench for sync_fifo_param (honours FIFO_ERR_EN)
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;
`ifdef FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr, rd, err_clr;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  int checks   = 0;
  int failures = 0;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic [7:0] dout;
    int         tid;
  } vec_t;

  localparam int NV = 67;
  vec_t tbl [NV];

  function automatic fifo_status_t exp_st(input int c);
    fifo_status_t s;
    s.full         = (c == 16);
    s.empty        = (c == 0);
    s.almost_full  = (c >= 14);
    s.almost_empty = (c <= 2);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rdq, input logic [7:0] d, input logic ec);
    @(negedge clk);
    reset = r; wr = w; rd = rdq; data_in = d; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int c, input logic [7:0] dout);
    fifo_status_t s;
    s = exp_st(c);
    chk({nm, " count"}, 32'(count), 32'(c));
    chk({nm, " status"}, 32'({full, empty, almost_full, almost_empty}), 32'(s));
    chk({nm, " data_out"}, 32'(data_out), 32'(dout));
  endtask

  logic [7:0] sb [$];
  logic [7:0] v;

  initial begin
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) tbl[n++] = '{1'b1, 1'b0, 8'(i + 1), 5'(i + 1), 8'h00, 1};
    for (int i = 0; i < 16; i++) tbl[n++] = '{1'b0, 1'b1, 8'h00, 5'(15 - i), 8'(i + 1), 1};
    for (int i = 0; i < 16; i++) tbl[n++] = '{1'b1, 1'b0, 8'(i + 1), 5'(i + 1), 8'h10, 2};
    tbl[n++] = '{1'b1, 1'b1, 8'hAA, 5'd16, 8'h01, 2};
    for (int i = 0; i < 15; i++) tbl[n++] = '{1'b0, 1'b1, 8'h00, 5'(15 - i), 8'(2 + i), 2};
    tbl[n++] = '{1'b0, 1'b1, 8'h00, 5'd0, 8'hAA, 2};
    tbl[n++] = '{1'b1, 1'b1, 8'h55, 5'd1, 8'hAA, 3};
    tbl[n++] = '{1'b0, 1'b1, 8'h00, 5'd0, 8'h55, 3};

    reset = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0; err_clr = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_state("reset", 0, 8'h00);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset underflow", 32'(underflow), 32'd0);

    // Tests 1-3: fill/drain order, wr+rd when full, wr+rd when empty.
    for (int i = 0; i < NV; i++) begin
      step(1'b0, tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0);
      chk($sformatf("t%0d[%0d]", tbl[i].tid, i), 0, 0 * 0 + 0) ;
      chk_state($sformatf("t%0d[%0d]", tbl[i].tid, i), int'(tbl[i].cnt), tbl[i].dout);
    end
    chk("t3 underflow", 32'(underflow), 32'(ERR));

    // Test 4: overflow on writes 17..20, clear, underflow on empty read, error beats clear.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4 clr overflow", 32'(overflow), 32'd0);
    chk("t4 clr underflow", 32'(underflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
      chk($sformatf("t4 wr%0d count", i), 32'(count), 32'((i < 16) ? i + 1 : 16));
      chk($sformatf("t4 wr%0d overflow", i), 32'(overflow), 32'((i >= 16) ? ERR : 1'b0));
    end
    chk("t4 full", 32'(full), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4 overflow cleared", 32'(overflow), 32'd0);
    chk("t4 count after clr", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      chk($sformatf("t4 rd%0d data", i), 32'(data_out), 32'(8'h60 + i));
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("t4 rd empty", 0, 8'h6F);
    chk("t4 underflow", 32'(underflow), 32'(ERR));
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("t4 error wins", 32'(underflow), 32'(ERR));
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4 underflow cleared", 32'(underflow), 32'd0);

    // Test 5: reset with a concurrent write discards everything.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    chk("t5 count 10", 32'(count), 32'd10);
    step(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
    chk_state("t5 after reset", 0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_state("t5 idle", 0, 8'h00);

    // Test 6: 40 write/read pairs with random data, pointers wrap.
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      step(1'b0, 1'b1, 1'b0, v, 1'b0);
      sb.push_back(v);
      chk($sformatf("t6 pair%0d count", i), 32'(count), 32'd1);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      chk($sformatf("t6 pair%0d data", i), 32'(data_out), 32'(sb.pop_front()));
    end
    chk("t6 empty", 32'(empty), 32'd1);
    chk("t6 overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
